// File: rtl/norm_scaler_lanes.sv
`default_nettype none
// ==========================================================================
// norm_scaler_lanes - per-frame reciprocal pixel scaler, LANES px/beat, FWFT out
// Optional macro NORM_ROUND_EN: round half up instead of truncate.  Rev 1.0
// ==========================================================================
module norm_scaler_lanes #(
    parameter int PIX_W        = 8,
    parameter int OUT_W        = 8,
    parameter int LANES        = 1,
    parameter int COEF_FRAC    = 24,
    parameter int FRAME_PIXELS = 100,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   ap_start,
    input  logic                   cf_ap_done,
    output logic                   ap_ready,
    output logic                   ap_done,
    input  logic [PIX_W-1:0]       norm_denominator,
    output logic                   err_div0,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [LANES*PIX_W-1:0] s_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [LANES*OUT_W-1:0] m_axis_tdata,
    output logic                   m_axis_tlast
);
    localparam int QW    = OUT_W + COEF_FRAC;
    localparam int PW    = PIX_W + QW;
    localparam int DW    = LANES * OUT_W;
    localparam int BEATS = FRAME_PIXELS / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 2;
    localparam int DCW   = (QW > 1) ? $clog2(QW) : 1;
    localparam logic [BW-1:0]  LAST_BEAT  = BW'(BEATS - 1);
    localparam logic [DCW-1:0] DIV_TOP    = DCW'(QW - 1);
    localparam logic [DCW-1:0] FRAC_IDX   = DCW'(COEF_FRAC);
    localparam logic [CW-1:0]  CREDIT_MAX = CW'(FIFO_DEPTH - 3);
    localparam logic [PW:0]    SAT_VAL    = (PW+1)'((1 << OUT_W) - 1);
`ifdef NORM_ROUND_EN
    localparam logic [PW:0]    RND_HALF   = (PW+1)'(1) << (COEF_FRAC - 1);
`endif

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CALC    = 3'd1,
        WAIT_UP = 3'd2,
        RUN     = 3'd3,
        DRAIN   = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [PIX_W-1:0] denom;
    logic [PIX_W:0]   rem, rem_sh, rem_nxt;
    logic [QW-1:0]    coef;
    logic [DCW-1:0]   div_cnt;
    logic             div_q;
    logic             up_done;
    logic [BW-1:0]    beat;
    logic             in_fire, out_fire;
    logic             s1_valid, s1_last, s2_valid, s2_last;
    logic [PW-1:0]    s1_prod [LANES];
    logic [PW:0]      shr;
    logic [DW-1:0]    s2_nxt, s2_data;
    logic [DW:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;

    assign in_fire       = s_axis_tvalid && s_axis_tready;
    assign out_fire      = m_axis_tvalid && m_axis_tready;
    assign s_axis_tready = (state == RUN) &&
                           ((count + CW'(s1_valid) + CW'(s2_valid)) <= CREDIT_MAX);
    assign m_axis_tvalid = (count != '0);
    assign {m_axis_tlast, m_axis_tdata} = m_axis_tvalid ? mem[rd_ptr] : '0;

    // Restoring division of the constant (2^OUT_W-1)<<COEF_FRAC, MSB first.
    always_comb begin
        rem_sh  = (rem << 1) | (PIX_W+1)'(div_cnt >= FRAC_IDX);
        div_q   = (rem_sh >= {1'b0, denom});
        rem_nxt = div_q ? (rem_sh - {1'b0, denom}) : rem_sh;
    end

    always_comb begin
        state_nxt = state;
        ap_ready  = 1'b0;
        ap_done   = 1'b0;
        case (state)
            IDLE: begin
                ap_ready = 1'b1;
                if (ap_start) state_nxt = CALC;
            end
            CALC:    if (denom == '0 || div_cnt == '0) state_nxt = WAIT_UP;
            WAIT_UP: if (up_done) state_nxt = RUN;
            RUN:     if (in_fire && beat == LAST_BEAT) state_nxt = DRAIN;
            DRAIN: begin
                if (out_fire && m_axis_tlast) begin
                    ap_done   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state    <= IDLE;
            denom    <= '0;
            rem      <= '0;
            coef     <= '0;
            div_cnt  <= '0;
            err_div0 <= 1'b0;
            up_done  <= 1'b0;
            beat     <= '0;
        end else begin
            state <= state_nxt;
            if (state != IDLE && cf_ap_done) up_done <= 1'b1;
            case (state)
                IDLE: begin
                    if (ap_start) begin
                        denom    <= norm_denominator;
                        err_div0 <= 1'b0;
                        up_done  <= 1'b0;
                        rem      <= '0;
                        coef     <= '0;
                        div_cnt  <= DIV_TOP;
                    end
                end
                CALC: begin
                    if (denom == '0) begin
                        coef     <= '1;
                        err_div0 <= 1'b1;
                    end else begin
                        rem     <= rem_nxt;
                        coef    <= {coef[QW-2:0], div_q};
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
            if (in_fire) beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
        end
    end

    always_comb begin
        s2_nxt = '0;
        shr    = '0;
        for (int l = 0; l < LANES; l++) begin
`ifdef NORM_ROUND_EN
            shr = ({1'b0, s1_prod[l]} + RND_HALF) >> COEF_FRAC;
`else
            shr = {1'b0, s1_prod[l]} >> COEF_FRAC;
`endif
            s2_nxt[l*OUT_W +: OUT_W] = (shr > SAT_VAL) ? SAT_VAL[OUT_W-1:0] : shr[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
        end else begin
            s1_valid <= in_fire;
            s1_last  <= in_fire && (beat == LAST_BEAT);
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            for (int l = 0; l < LANES; l++)
                s1_prod[l] <= PW'(s_axis_tdata[l*PIX_W +: PIX_W]) * PW'(coef);
        end
        if (s1_valid) s2_data <= s2_nxt;
        if (s2_valid) mem[wr_ptr] <= {s2_last, s2_data};
    end

    // The input credit check keeps count+inflight below depth, so no full flag is needed.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (s2_valid) wr_ptr <= wr_ptr + 1'b1;
            if (out_fire) rd_ptr <= rd_ptr + 1'b1;
            case ({s2_valid, out_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_norm_scaler_lanes.sv
`default_nettype none
// ==========================================================================
// tb_norm_scaler_lanes - randomized frames checked against a reciprocal model
// Rev 1.0
// ==========================================================================
module tb_norm_scaler_lanes;
    localparam int PIX_W        = 8;
    localparam int OUT_W        = 8;
    localparam int LANES        = 4;
    localparam int COEF_FRAC    = 24;
    localparam int FRAME_PIXELS = 48;
    localparam int FIFO_DEPTH   = 8;
    localparam int BEATS        = FRAME_PIXELS / LANES;
    localparam int QW           = OUT_W + COEF_FRAC;

    logic                   clk = 1'b0;
    logic                   srst, ap_start, cf_ap_done, ap_ready, ap_done, err_div0;
    logic [PIX_W-1:0]       norm_denominator;
    logic                   s_axis_tvalid, s_axis_tready, m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [LANES*PIX_W-1:0] s_axis_tdata;
    logic [LANES*OUT_W-1:0] m_axis_tdata;

    int checks = 0;
    int errors = 0;
    int pix     [FRAME_PIXELS];
    int exp_pix [FRAME_PIXELS];

    always #5 clk = ~clk;

    norm_scaler_lanes #(
        .PIX_W(PIX_W), .OUT_W(OUT_W), .LANES(LANES), .COEF_FRAC(COEF_FRAC),
        .FRAME_PIXELS(FRAME_PIXELS), .FIFO_DEPTH(FIFO_DEPTH)
    ) u_dut (
        .clk(clk), .srst(srst), .ap_start(ap_start), .cf_ap_done(cf_ap_done),
        .ap_ready(ap_ready), .ap_done(ap_done), .norm_denominator(norm_denominator),
        .err_div0(err_div0), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scale by (2^OUT_W-1)/denom through a truncated fixed-point reciprocal.
    function automatic int model(input int p, input int d);
        longint unsigned maxv, coef, prod, res;
        maxv = (64'd1 << OUT_W) - 1;
        if (d == 0) coef = (64'd1 << QW) - 1;
        else        coef = (maxv << COEF_FRAC) / longint'(d);
        prod = longint'(p) * coef;
`ifdef NORM_ROUND_EN
        prod = prod + (64'd1 << (COEF_FRAC - 1));
`endif
        res = prod >> COEF_FRAC;
        return int'((res > maxv) ? maxv : res);
    endfunction

    task automatic fill_random();
        for (int i = 0; i < FRAME_PIXELS; i++) pix[i] = $urandom_range(255);
    endtask

    task automatic run_frame(input int denom, input int gap_pct, input int stall_pct,
                             input int bp_len, input int abort_at);
        int   in_idx = 0;
        int   out_idx = 0;
        int   cyc = 0;
        int   first_acc = -1;
        int   cf_at;
        bit   prev_stall = 1'b0;
        bit   fire;
        logic [LANES*OUT_W-1:0] prev_data = '0;
        logic prev_last = 1'b0;
        for (int i = 0; i < FRAME_PIXELS; i++) exp_pix[i] = model(pix[i], denom);
        check("ap_ready_idle", ap_ready, 1);
        norm_denominator = PIX_W'(denom);
        ap_start = 1'b1;
        @(posedge clk); #1;
        ap_start = 1'b0;
        check("ap_ready_busy", ap_ready, 0);
        cf_at = $urandom_range(60);
        forever begin
            cf_ap_done    = (cyc == cf_at);
            s_axis_tvalid = (in_idx < BEATS) && ($urandom_range(99) >= gap_pct);
            s_axis_tdata  = '0;
            if (in_idx < BEATS)
                for (int l = 0; l < LANES; l++)
                    s_axis_tdata[l*PIX_W +: PIX_W] = PIX_W'(pix[in_idx*LANES + l]);
            if (first_acc >= 0 && cyc >= first_acc + 2 && cyc < first_acc + 2 + bp_len)
                m_axis_tready = 1'b0;
            else
                m_axis_tready = ($urandom_range(99) >= stall_pct);
            @(negedge clk);
            if (in_idx > 0 && in_idx < BEATS)
                check("tready_credit", s_axis_tready, (in_idx - out_idx) <= FIFO_DEPTH - 3);
            else if (in_idx == BEATS)
                check("tready_after_last", s_axis_tready, 0);
            if (first_acc >= 0 && cyc == first_acc + 2) check("latency_early", m_axis_tvalid, 0);
            if (first_acc >= 0 && cyc == first_acc + 3) check("latency", m_axis_tvalid, 1);
            if (prev_stall) begin
                check("hold_data", m_axis_tdata, prev_data);
                check("hold_last", m_axis_tlast, prev_last);
            end
            fire = m_axis_tvalid && m_axis_tready;
            check("ap_done", ap_done, fire && (out_idx == BEATS - 1));
            if (fire) begin
                for (int l = 0; l < LANES; l++)
                    check("data", m_axis_tdata[l*OUT_W +: OUT_W], exp_pix[out_idx*LANES + l]);
                check("tlast", m_axis_tlast, out_idx == BEATS - 1);
                out_idx++;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
            if (s_axis_tvalid && s_axis_tready) begin
                if (first_acc < 0) first_acc = cyc;
                in_idx++;
            end
            @(posedge clk); #1;
            cyc++;
            if (out_idx == BEATS || (abort_at > 0 && in_idx >= abort_at)) break;
            if (cyc > 3000) begin
                check("timeout", 0, 1);
                break;
            end
        end
        s_axis_tvalid = 1'b0;
        cf_ap_done    = 1'b0;
        m_axis_tready = 1'b0;
        if (abort_at > 0) begin
            srst = 1'b1;
            @(posedge clk); #1;
            srst = 1'b0;
            m_axis_tready = 1'b1;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                check("rst_no_done", ap_done, 0);
                check("rst_empty", m_axis_tvalid, 0);
                check("rst_ready", ap_ready, 1);
            end
            @(posedge clk); #1;
            m_axis_tready = 1'b0;
        end else begin
            check("ap_ready_after", ap_ready, 1);
            check("ap_done_pulse", ap_done, 0);
            check("err_div0", err_div0, denom == 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got 0 expected 1");
        $fatal(1, "watchdog expired");
    end

    initial begin
        srst = 1'b1;
        ap_start = 1'b0;
        cf_ap_done = 1'b0;
        norm_denominator = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata = '0;
        m_axis_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1 srst = 1'b0;
        @(negedge clk);
        check("rst_ap_ready", ap_ready, 1);
        check("rst_ap_done", ap_done, 0);
        check("rst_err_div0", err_div0, 0);
        check("rst_s_tready", s_axis_tready, 0);
        check("rst_m_tvalid", m_axis_tvalid, 0);
        check("rst_m_tlast", m_axis_tlast, 0);
        check("rst_m_tdata", m_axis_tdata, 0);
        @(posedge clk); #1;

        fill_random();
        pix[0] = 100; pix[1] = 150; pix[2] = 250; pix[3] = 0;
        run_frame(200, 20, 20, 0, 0);

        fill_random();
        pix[0] = 1; pix[5] = 1;
        run_frame(2, 10, 30, 0, 0);

        fill_random();
        pix[0] = 0; pix[1] = 5;
        run_frame(0, 0, 0, 0, 0);

        fill_random();
        pix[0] = 1; pix[1] = 2; pix[2] = 3; pix[3] = 0;
        pix[4] = 3; pix[5] = 3; pix[6] = 3; pix[7] = 3;
        run_frame(3, 30, 10, 0, 0);

        fill_random();
        run_frame($urandom_range(255, 1), 0, 0, 40, 0);

        fill_random();
        run_frame($urandom_range(255, 1), 0, 50, 0, 5);

        fill_random();
        run_frame(255, 10, 10, 0, 0);

        for (int f = 0; f < 4; f++) begin
            fill_random();
            run_frame($urandom_range(255), $urandom_range(50), $urandom_range(60), $urandom_range(20), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/norm_scaler_lanes.md
Name: norm_scaler_lanes

Overview:
Parameterised successor to the single-lane pixel normaliser. It scales every pixel of one post-crop frame by (2^OUT_W-1)/norm_denominator and carries LANES pixels per beat. The reciprocal is computed once per frame by an internal sequential divider, replacing the LUT. The block sits between the crop filter and the downstream inference stream, handles ap_start/ap_done/ap_ready, and buffers its output in an internal FIFO.

Parameters:
PIX_W, 8, input pixel width (bits)
OUT_W, 8, output pixel width (bits)
LANES, 1, pixels per AXI-Stream beat
COEF_FRAC, 24, fractional bits of reciprocal coefficient
FRAME_PIXELS, 100, pixels per frame; must be a multiple of LANES
FIFO_DEPTH, 16, output FIFO entries (power of 2, >=4)

Ports:
clk  in  1  clock
srst  in  1  synchronous active-high reset
ap_start  in  1  frame start request
cf_ap_done  in  1  upstream crop filter done; enables input acceptance
ap_ready  out  1  high in IDLE
ap_done  out  1  one-cycle pulse when the last output beat is accepted
norm_denominator  in  PIX_W  divisor, latched on accepted ap_start
err_div0  out  1  sticky per frame: latched denominator was 0
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tdata  in  LANES*PIX_W  pixels, lane 0 in LSBs
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tdata  out  LANES*OUT_W  normalised pixels, lane 0 in LSBs
m_axis_tlast  out  1  high on final beat of frame

Behaviour:
- Single clock clk. srst is synchronous, active-high.
- Reset state: state=IDLE; FIFO empty; counters 0; all outputs 0 except ap_ready=1.
- srst mid-frame: in-flight pipeline data and FIFO contents are discarded, with no ap_done.
- FSM states: IDLE, CALC, WAIT_UP, RUN, DRAIN.
  - IDLE: ap_ready=1. ap_start latches norm_denominator, clears err_div0 and the done flag, and moves to CALC. ap_start is ignored in all other states.
  - CALC: restoring divider, one quotient bit per cycle, OUT_W+COEF_FRAC cycles. Computes coef = floor((2^OUT_W-1)*2^COEF_FRAC / denom).
    - denom=0: skip the division, set coef to all ones, set err_div0, and go to WAIT_UP next cycle.
  - WAIT_UP: wait for the sticky done flag, which is set by cf_ap_done in any non-IDLE state. Then go to RUN.
  - RUN: accept input beats. After beat FRAME_PIXELS/LANES is accepted, go to DRAIN.
  - DRAIN: when the final output beat handshakes (m_axis_tvalid && m_axis_tready && m_axis_tlast), pulse ap_done and go to IDLE.
- Arithmetic, per lane:
  - prod = pixel * coef; res = prod >> COEF_FRAC, truncated.
  - If res > 2^OUT_W-1, saturate to 2^OUT_W-1.
  - Pixel 0 always gives 0.
- Pipeline: stage 1 registers the multiply; stage 2 registers shift/saturate and the tlast tag, then writes the FIFO.
  - With the FIFO empty, an input accepted at cycle t gives m_axis_tvalid=1 at t+3.
- Input handshake: s_axis_tready = (state==RUN) && (fifo_count + inflight <= FIFO_DEPTH-3).
  - The credit scheme guarantees no FIFO overflow. Data is never dropped.
- Output: first-word-fall-through FIFO. m_axis_tvalid = !empty.
  - tdata/tlast are held stable while tvalid && !tready.
  - A simultaneous FIFO read and write leaves the count unchanged.
- Beat counter: wraps to 0 at end of frame. tlast is asserted only on beat index FRAME_PIXELS/LANES-1.

Optional Feature:
NORM_ROUND_EN
- Defined: res = (prod + 2^(COEF_FRAC-1)) >> COEF_FRAC (round half up), then saturate.
- Undefined: truncation as above.
- Pipeline latency is unchanged either way.

Test Plan:
1. LANES=1, denom=200, pixels 100,150,250,0 -> outputs 127,191,255,0. ap_done pulses once after the 4th output, using FRAME_PIXELS=4.
2. denom=2, pixel=1 -> 127 without NORM_ROUND_EN; 128 with NORM_ROUND_EN.
3. denom=0, pixels 0,5 -> err_div0=1; outputs 0,255; frame completes with ap_done.
4. LANES=4, FRAME_PIXELS=8, denom=3, beat {1,2,3,0} then {3,3,3,3} -> {85,170,255,0}, {255,255,255,255}. tlast is set on beat 2 only.
5. Backpressure: m_axis_tready=0 for 40 cycles during RUN.
   - s_axis_tready drops by the time FIFO_DEPTH-2 entries are committed or in flight.
   - No loss; output order matches input; output data is stable while stalled.
6. srst asserted mid-RUN, then ap_start with denom=255 -> no spurious ap_done. New frame outputs equal the inputs (pixel p -> p).
